// File: rtl/full_adder_cell.sv
// WIDTH-bit ripple-carry adder built from per-bit full-adder cells, with a valid-qualified registered copy.
// Optional overflow outputs (ovf, ovf_q) are enabled by defining FULL_ADDER_CELL_OVF_EN.
module full_adder_cell #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
`ifdef FULL_ADDER_CELL_OVF_EN
  output logic             ovf,
  output logic             ovf_q,
`else
  // overflow outputs absent in the default build
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] sum_q,
  output logic             c_out_q
);

  localparam int unsigned CW = WIDTH + 1;

  // carry[i] is the carry into bit i; carry[WIDTH] is the final carry out
  logic [CW-1:0] carry;

  assign carry[0] = c_in;

  // Ripple chain: one full-adder cell per bit
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic p;
    logic g;

    assign p            = a[i] ^ b[i];
    assign g            = a[i] & b[i];
    assign sum[i]       = p ^ carry[i];
    assign carry[i + 1] = g | (carry[i] & p);
  end

  assign c_out = carry[WIDTH];

`ifdef FULL_ADDER_CELL_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it
  assign ovf = carry[WIDTH] ^ carry[WIDTH - 1];
`else
  // no overflow detection in the default build
`endif

  // Pipelined copy: valid always advances, payload captured only when valid
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum_q     <= '0;
      c_out_q   <= 1'b0;
`ifdef FULL_ADDER_CELL_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q   <= sum;
        c_out_q <= c_out;
`ifdef FULL_ADDER_CELL_OVF_EN
        ovf_q   <= ovf;
`endif
      end
    end
  end

endmodule

// File: tb/tb_full_adder_cell.sv
// Directed self-checking bench for full_adder_cell: 1-bit truth table plus 8-bit combinational and registered paths.
// Overflow checks are compiled in when FULL_ADDER_CELL_OVF_EN is defined.
module tb_full_adder_cell;

  logic       clk;
  logic       rst;

  logic       in_valid1;
  logic [0:0] a1, b1;
  logic       c_in1;
  logic [0:0] sum1, sum_q1;
  logic       c_out1, out_valid1, c_out_q1;

  logic       in_valid8;
  logic [7:0] a8, b8;
  logic       c_in8;
  logic [7:0] sum8, sum_q8;
  logic       c_out8, out_valid8, c_out_q8;

`ifdef FULL_ADDER_CELL_OVF_EN
  logic       ovf1, ovf_q1, ovf8, ovf_q8;
`endif

  int total;
  int bad;

  logic [1:0] tt [8];

  full_adder_cell #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .a         (a1),
    .b         (b1),
    .c_in      (c_in1),
    .sum       (sum1),
    .c_out     (c_out1),
`ifdef FULL_ADDER_CELL_OVF_EN
    .ovf       (ovf1),
    .ovf_q     (ovf_q1),
`endif
    .out_valid (out_valid1),
    .sum_q     (sum_q1),
    .c_out_q   (c_out_q1)
  );

  full_adder_cell #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .a         (a8),
    .b         (b8),
    .c_in      (c_in8),
    .sum       (sum8),
    .c_out     (c_out8),
`ifdef FULL_ADDER_CELL_OVF_EN
    .ovf       (ovf8),
    .ovf_q     (ovf_q8),
`endif
    .out_valid (out_valid8),
    .sum_q     (sum_q8),
    .c_out_q   (c_out_q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    a8    = a;
    b8    = b;
    c_in8 = ci;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    tt[0] = 2'b00; tt[1] = 2'b01; tt[2] = 2'b01; tt[3] = 2'b10;
    tt[4] = 2'b01; tt[5] = 2'b10; tt[6] = 2'b10; tt[7] = 2'b11;

    rst       = 1'b1;
    in_valid1 = 1'b0;
    in_valid8 = 1'b0;
    a1 = '0; b1 = '0; c_in1 = 1'b0;
    drive8(8'h00, 8'h00, 1'b0);

    // 1-bit truth table, indexed by {a, b, c_in}
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1    = v[2];
      b1    = v[1];
      c_in1 = v[0];
      #1;
      check($sformatf("tt%0d", i), 64'({c_out1, sum1}), 64'(tt[i]));
`ifdef FULL_ADDER_CELL_OVF_EN
      check($sformatf("tt_ovf%0d", i), 64'(ovf1), 64'(tt[i][1] ^ v[0]));
`endif
    end

    // 8-bit combinational vectors: {c_out, sum}
    drive8(8'hFF, 8'h01, 1'b0); #1; check("ff+01+0", 64'({c_out8, sum8}), 64'h100);
    drive8(8'hFF, 8'hFF, 1'b1); #1; check("ff+ff+1", 64'({c_out8, sum8}), 64'h1FF);
    drive8(8'h55, 8'hAA, 1'b0); #1; check("55+aa+0", 64'({c_out8, sum8}), 64'h0FF);
    drive8(8'h0F, 8'h01, 1'b1); #1; check("0f+01+1", 64'({c_out8, sum8}), 64'h011);
    drive8(8'h00, 8'h00, 1'b1); #1; check("00+00+1", 64'({c_out8, sum8}), 64'h001);

    // Reset for two cycles
    tick();
    tick();
    check("rst_valid", 64'(out_valid8), 64'h0);
    check("rst_sum_q", 64'(sum_q8), 64'h0);
    check("rst_cout_q", 64'(c_out_q8), 64'h0);
    check("rst_valid1", 64'(out_valid1), 64'h0);
    check("rst_sum_q1", 64'({c_out_q1, sum_q1}), 64'h0);
`ifdef FULL_ADDER_CELL_OVF_EN
    check("rst_ovf_q", 64'(ovf_q8), 64'h0);
`endif

    // First capture
    rst       = 1'b0;
    in_valid8 = 1'b1;
    drive8(8'h12, 8'h34, 1'b1);
    tick();
    check("cap_valid", 64'(out_valid8), 64'h1);
    check("cap_sum_q", 64'(sum_q8), 64'h47);
    check("cap_cout_q", 64'(c_out_q8), 64'h0);

    // Hold while in_valid is low; combinational path moves immediately
    in_valid8 = 1'b0;
    a8        = 8'hAA;
    #1;
    check("hold_comb", 64'({c_out8, sum8}), 64'h0DF);
    tick();
    check("hold_valid", 64'(out_valid8), 64'h0);
    check("hold_sum_q", 64'(sum_q8), 64'h47);
    tick();
    check("hold2_sum_q", 64'(sum_q8), 64'h47);

    // Reset wins over in_valid on the same edge
    in_valid8 = 1'b1;
    drive8(8'hFF, 8'h01, 1'b0);
    rst = 1'b1;
    tick();
    check("prio_valid", 64'(out_valid8), 64'h0);
    check("prio_sum_q", 64'(sum_q8), 64'h0);
    check("prio_cout_q", 64'(c_out_q8), 64'h0);

    // Release reset with in_valid still high, then back-to-back captures
    rst = 1'b0;
    drive8(8'h20, 8'h30, 1'b0);
    tick();
    check("rel_valid", 64'(out_valid8), 64'h1);
    check("rel_sum_q", 64'({c_out_q8, sum_q8}), 64'h050);
    drive8(8'hF0, 8'h20, 1'b0);
    tick();
    check("b2b1_valid", 64'(out_valid8), 64'h1);
    check("b2b1_q", 64'({c_out_q8, sum_q8}), 64'h110);
    drive8(8'h01, 8'h01, 1'b0);
    tick();
    check("b2b2_q", 64'({c_out_q8, sum_q8}), 64'h002);

`ifdef FULL_ADDER_CELL_OVF_EN
    // Signed overflow, combinational and registered
    drive8(8'h7F, 8'h01, 1'b0);
    #1;
    check("ovf_7f", 64'(ovf8), 64'h1);
    tick();
    check("ovf_q_7f", 64'(ovf_q8), 64'h1);
    drive8(8'h80, 8'h80, 1'b0);
    #1;
    check("ovf_80", 64'({ovf8, c_out8}), 64'h3);
    drive8(8'h01, 8'h01, 1'b0);
    #1;
    check("ovf_01", 64'(ovf8), 64'h0);
    tick();
    check("ovf_q_01", 64'(ovf_q8), 64'h0);
    in_valid8 = 1'b0;
    drive8(8'h7F, 8'h01, 1'b0);
    tick();
    check("ovf_q_hold", 64'(ovf_q8), 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/full_adder_cell.md
Name: full_adder_cell

Overview:
- WIDTH-bit ripple-carry full adder built from per-bit full-adder cells.
- Default WIDTH=1 gives the classic 1-bit full adder: a + b + c_in -> {c_out, sum}.
- Combinational outputs feed datapath logic directly.
- A registered copy, qualified by a valid flag, supports pipelined use in the microprocessor datapath.

Parameters:
- WIDTH, 1, operand width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock; used only by the registered copy.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies a/b/c_in for the registered copy.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c_in  input  1  carry into bit 0.
- sum  output  WIDTH  combinational sum bits.
- c_out  output  1  combinational carry out of bit WIDTH-1.
- out_valid  output  1  registered in_valid.
- sum_q  output  WIDTH  registered sum.
- c_out_q  output  1  registered c_out.

Behaviour:
- Combinational path, zero latency:
  - {c_out, sum} = a + b + c_in, computed at WIDTH+1 bits with no truncation.
  - Outputs settle within the same simulation time step as an input change. There is no dependence on clk or rst.
- Cell equations, bit i:
  - s_i = a_i ^ b_i ^ c_i
  - c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i))
  - c_0 = c_in; c_out = c_WIDTH.
- Required truth table (WIDTH=1, inputs listed as a b c_in -> c_out sum):
  - 000->00, 001->01, 010->01, 011->10
  - 100->01, 101->10, 110->10, 111->11
- Registered path, 1-cycle latency:
  - On each rising clk with rst=0:
    - out_valid <= in_valid.
    - If in_valid=1: sum_q <= sum, c_out_q <= c_out.
    - If in_valid=0: sum_q and c_out_q hold their values.
  - On a rising clk with rst=1: out_valid, sum_q, c_out_q all <= 0. Reset takes priority over in_valid.
  - Reset asserted mid-stream discards the in-flight result. The first result after reset deasserts appears one cycle after the first accepted in_valid.
- Back-to-back in_valid is accepted every cycle; there is no backpressure.
- X/Z on inputs propagates to outputs; no masking logic.
- Wrap-around: all-ones + all-ones + 1 gives sum = all-ones, c_out = 1.

Optional Feature:
- Macro FULL_ADDER_CELL_OVF_EN.
- When defined, two extra outputs are added:
  - ovf  output  1: combinational two's-complement overflow, c_WIDTH ^ c_(WIDTH-1). For WIDTH=1, c_(WIDTH-1) is c_in.
  - ovf_q  output  1: registered copy of ovf. It follows the same capture/hold/reset rules as c_out_q and resets to 0.
- When not defined, neither port exists and the other behaviour is identical.

Test Plan:
- Exhaustive WIDTH=1 sweep of all 8 a/b/c_in combinations, checked 1 time unit after each change -> c_out/sum match the truth table, e.g. a=1 b=1 c_in=1 -> c_out=1 sum=1.
- WIDTH=8 with a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1. Then a=8'hFF, b=8'hFF, c_in=1 -> sum=8'hFF, c_out=1.
- Registered path, WIDTH=8:
  - Reset 2 cycles -> out_valid=0, sum_q=0, c_out_q=0.
  - Drive in_valid=1, a=8'h12, b=8'h34, c_in=1 -> next edge: out_valid=1, sum_q=8'h47, c_out_q=0.
- Hold: after the capture above, drive in_valid=0, a=8'hAA -> sum_q stays 8'h47, out_valid=0, while combinational sum changes immediately.
- Reset priority: in_valid=1 and rst=1 on the same edge -> out_valid=0, sum_q=0. Releasing rst with in_valid still 1 -> valid result one edge later.
- FULL_ADDER_CELL_OVF_EN with WIDTH=8:
  - a=8'h7F, b=8'h01, c_in=0 -> ovf=1; one edge after in_valid -> ovf_q=1.
  - a=8'h80, b=8'h80, c_in=0 -> ovf=1, c_out=1.
  - a=8'h01, b=8'h01 -> ovf=0.
